// File: rtl/spi_reg_master_pkg.sv
// Shared types and constants for the SPI register master
// and the register map of the slave it talks to.
package spi_reg_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT_HI,
    SHIFT_LO,
    TRAIL
  } state_t;

  localparam int RW_BIT = 7;

  localparam logic [6:0] REG_VERSION = 7'h00;
  localparam logic [6:0] REG_STATUS  = 7'h01;
  localparam logic [6:0] REG_SCRATCH = 7'h0d;

  function automatic logic [15:0] frame(
    input logic       wr,
    input logic [6:0] rn,
    input logic [7:0] wd
  );
    logic [7:0] cmd;
    cmd = {1'b0, rn};
    cmd[RW_BIT] = wr;
    return {cmd, wr ? wd : 8'h00};
  endfunction

endpackage

// File: rtl/spi_reg_if.sv
// Host request/response and SPI pin bundle
// for the SPI register master.
interface spi_reg_if;
  import spi_reg_master_pkg::*;

  logic       start;
  logic       write;
  logic [6:0] regnum;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       ss;
  logic       sclk;
  logic       mosi;
  logic       miso;

  modport master (
    input  start, write, regnum, wdata, miso,
    output busy, done, rdata, ss, sclk, mosi
  );

  modport slave (
    output start, write, regnum, wdata, miso,
    input  busy, done, rdata, ss, sclk, mosi
  );

endinterface

// File: rtl/spi_reg_master_tick.sv
// SCLK half-period tick: pulses on the last clk
// of every CLK_DIV-cycle window while enabled.
module spi_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= 8'd0;
    end else if (cnt == LAST) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 master issuing 16-bit register
// read/write frames: command byte then data byte.
module spi_reg_master
  import spi_reg_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input logic        clk,
  input logic        rst,
  spi_reg_if.master  bus
);

  state_t      state;
  state_t      nxt;
  logic        tick;
  logic        en;
  logic        accept;
  logic        sclk_c;
  logic        ss_c;
  logic        done_c;
  logic [15:0] tx;
  logic [3:0]  bit_cnt;
  logic        mosi_q;
  logic [7:0]  rx;
  logic [7:0]  rdata_q;
  logic [1:0]  sync;

  assign accept = bus.start
    && (state == IDLE || state == TRAIL);

  spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt    = state;
    en     = 1'b0;
    sclk_c = 1'b0;
    ss_c   = 1'b1;
    done_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) nxt = LEAD;
      end
      LEAD: begin
        en   = 1'b1;
        ss_c = 1'b0;
        if (tick) nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        en     = 1'b1;
        ss_c   = 1'b0;
        sclk_c = 1'b1;
        if (tick) nxt = SHIFT_LO;
      end
      SHIFT_LO: begin
        en   = 1'b1;
        ss_c = 1'b0;
        if (tick) begin
          nxt = (bit_cnt == 4'd0) ? TRAIL : SHIFT_HI;
        end
      end
      TRAIL: begin
        done_c = 1'b1;
        nxt    = bus.start ? LEAD : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // miso is asynchronous to clk
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], bus.miso};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= 16'h0000;
      bit_cnt <= 4'd0;
      mosi_q  <= 1'b0;
      rx      <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      if (accept) begin
        tx      <= frame(bus.write, bus.regnum, bus.wdata);
        bit_cnt <= 4'd15;
        mosi_q  <= bus.write;
      end
      // sample at the end of sclk high, shift out on the fall
      if (state == SHIFT_HI && tick) begin
        rx <= {rx[6:0], sync[1]};
        if (bit_cnt != 4'd0) begin
          mosi_q <= tx[bit_cnt - 4'd1];
        end
      end
      if (state == SHIFT_LO && tick) begin
        if (bit_cnt == 4'd0) begin
          rdata_q <= rx;
        end else begin
          bit_cnt <= bit_cnt - 4'd1;
        end
      end
    end
  end

  assign bus.busy  = en;
  assign bus.done  = done_c;
  assign bus.ss    = ss_c;
  assign bus.sclk  = sclk_c;
  assign bus.mosi  = mosi_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed + random bench for spi_reg_master with a
// behavioural register-file SPI slave and reference model.
module tb_spi_reg_master;
  import spi_reg_master_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_reg_if b4 ();
  spi_reg_if b3 ();

  spi_reg_master #(.CLK_DIV(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4.master)
  );

  spi_reg_master #(.CLK_DIV(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3.master)
  );

  int checks = 0;
  int errors = 0;

  bit sel = 1'b0;
  logic miso = 1'b0;
  assign b4.miso = miso;
  assign b3.miso = miso;

  logic       s_ss, s_sclk, s_mosi, s_done, s_busy;
  logic [7:0] s_rdata;
  assign s_ss    = sel ? b3.ss    : b4.ss;
  assign s_sclk  = sel ? b3.sclk  : b4.sclk;
  assign s_mosi  = sel ? b3.mosi  : b4.mosi;
  assign s_done  = sel ? b3.done  : b4.done;
  assign s_busy  = sel ? b3.busy  : b4.busy;
  assign s_rdata = sel ? b3.rdata : b4.rdata;

  // slave register file and reference model
  logic [7:0] sreg [128] =
    '{0: 8'h10, 13: 8'h73, default: 8'h00};
  logic [7:0] mreg [128] =
    '{0: 8'h10, 13: 8'h73, default: 8'h00};

  logic [15:0] shreg = 16'h0;
  logic [6:0]  addr = 7'h0;
  logic [7:0]  dout = 8'h0;
  int          cnt = 0;
  logic        p_ss = 1'b1;
  logic        p_sclk = 1'b0;
  logic        p_mosi = 1'b0;
  int          frames = 0;
  int          frame_bits = 0;
  logic [15:0] frame_data = 16'h0;
  int          dones = 0;
  int          stab_err = 0;

  always @(negedge clk) begin
    if (s_ss) begin
      if (!p_ss) begin
        frames++;
        frame_bits = cnt;
        frame_data = shreg;
      end
      cnt = 0;
    end else begin
      if (s_sclk && !p_sclk) begin
        shreg = {shreg[14:0], s_mosi};
        cnt++;
        if (cnt == 8) begin
          addr = shreg[6:0];
          dout = sreg[addr];
        end
        if (cnt == 16 && shreg[15] && shreg[14:8] != 7'h00)
          sreg[shreg[14:8]] = shreg[7:0];
      end
      if (!s_sclk && p_sclk) begin
        if (cnt >= 8 && cnt < 16) miso = dout[15 - cnt];
        else miso = 1'($urandom);
      end
    end
    if (s_sclk && p_sclk && s_mosi !== p_mosi)
      stab_err++;
    if (s_mosi !== p_mosi && !(p_sclk && !s_sclk)
        && !(p_ss && !s_ss) && !s_ss)
      stab_err++;
    if (s_done) dones++;
    p_ss   = s_ss;
    p_sclk = s_sclk;
    p_mosi = s_mosi;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic st, input logic w,
                        input logic [6:0] r,
                        input logic [7:0] d);
    if (sel) begin
      b3.start = st; b3.write = w;
      b3.regnum = r; b3.wdata = d;
    end else begin
      b4.start = st; b4.write = w;
      b4.regnum = r; b4.wdata = d;
    end
  endtask

  task automatic launch(input logic w, input logic [6:0] r,
                        input logic [7:0] d, input bit armed);
    if (!armed) set_in(1'b1, w, r, d);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 7'h0, 8'h0);
    chk("c1_busy", 32'(s_busy), 1);
    chk("c1_ss", 32'(s_ss), 0);
    chk("c1_mosi", 32'(s_mosi), 32'(w));
  endtask

  task automatic wait_done(input int guard_at, output int n);
    n = 1;
    while (!s_done && n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (n == guard_at) set_in(1'b1, 1'b1, REG_STATUS, 8'hFF);
      if (n == guard_at + 1) set_in(1'b0, 1'b0, 7'h0, 8'h0);
    end
    if (!s_done) chk("done_timeout", 0, 1);
  endtask

  task automatic finish(input logic w, input logic [6:0] r,
                        input logic [7:0] d, input int guard_at,
                        input bit chain, input logic cw,
                        input logic [6:0] cr, input logic [7:0] cd);
    int n;
    int f0;
    int div;
    logic [7:0]  exp_rd;
    logic [15:0] exp_fr;
    f0 = frames;
    div = sel ? 3 : 4;
    exp_rd = mreg[r];
    exp_fr = {w, r, w ? d : 8'h00};
    wait_done(guard_at, n);
    chk("done_cycle", 32'(n), 32'(33 * div + 1));
    chk("done_ss", 32'(s_ss), 1);
    chk("done_busy", 32'(s_busy), 0);
    chk("rdata", 32'(s_rdata), 32'(exp_rd));
    if (w && r != 7'h00) mreg[r] = d;
    if (chain) set_in(1'b1, cw, cr, cd);
    @(negedge clk); #1;
    chk("frame_cnt", 32'(frames), 32'(f0 + 1));
    chk("frame_bits", 32'(frame_bits), 16);
    chk("frame_mosi", 32'(frame_data), 32'(exp_fr));
    if (!chain) begin
      @(posedge clk); #1;
      chk("done_pulse", 32'(s_done), 0);
      chk("rdata_hold", 32'(s_rdata), 32'(exp_rd));
    end
  endtask

  initial begin
    int d0;
    int f0;
    logic w;
    logic [6:0] r;
    logic [7:0] d;
    sel = 1'b1;
    set_in(1'b0, 1'b0, 7'h0, 8'h0);
    sel = 1'b0;
    set_in(1'b0, 1'b0, 7'h0, 8'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ss", 32'(b4.ss), 1);
    chk("rst_sclk", 32'(b4.sclk), 0);
    chk("rst_mosi", 32'(b4.mosi), 0);
    chk("rst_busy", 32'(b4.busy), 0);
    chk("rst_done", 32'(b4.done), 0);
    chk("rst_rdata", 32'(b4.rdata), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    launch(1'b0, REG_SCRATCH, 8'h00, 1'b0);
    finish(1'b0, REG_SCRATCH, 8'h00, 0, 1'b0, 0, 0, 0);
    chk("scratch_default", 32'(s_rdata), 32'h73);

    launch(1'b0, REG_VERSION, 8'h00, 1'b0);
    finish(1'b0, REG_VERSION, 8'h00, 0, 1'b0, 0, 0, 0);
    chk("version", 32'(s_rdata), 32'h10);

    launch(1'b1, REG_SCRATCH, 8'hA5, 1'b0);
    finish(1'b1, REG_SCRATCH, 8'hA5, 0, 1'b0, 0, 0, 0);
    chk("wr_frame", 32'(frame_data), 32'h8DA5);

    launch(1'b0, REG_SCRATCH, 8'h00, 1'b0);
    finish(1'b0, REG_SCRATCH, 8'h00, 0, 1'b0, 0, 0, 0);
    chk("scratch_rb", 32'(s_rdata), 32'hA5);

    d0 = dones;
    launch(1'b0, REG_STATUS, 8'h00, 1'b0);
    finish(1'b0, REG_STATUS, 8'h00, 50, 1'b0, 0, 0, 0);
    f0 = frames;
    repeat (150) @(posedge clk);
    #1;
    chk("guard_dones", 32'(dones), 32'(d0 + 1));
    chk("guard_frames", 32'(frames), 32'(f0));
    chk("guard_idle_ss", 32'(s_ss), 1);

    d0 = dones;
    launch(1'b1, REG_STATUS, 8'h5A, 1'b0);
    repeat (59) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ss", 32'(s_ss), 1);
    chk("abort_sclk", 32'(s_sclk), 0);
    chk("abort_busy", 32'(s_busy), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_nodone", 32'(dones), 32'(d0));
    chk("abort_rdata", 32'(s_rdata), 0);
    chk("abort_short", 32'(frame_bits < 16), 1);
    launch(1'b0, REG_VERSION, 8'h00, 1'b0);
    finish(1'b0, REG_VERSION, 8'h00, 0, 1'b0, 0, 0, 0);
    launch(1'b0, REG_STATUS, 8'h00, 1'b0);
    finish(1'b0, REG_STATUS, 8'h00, 0, 1'b0, 0, 0, 0);

    sel = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    launch(1'b1, REG_SCRATCH, 8'h3C, 1'b0);
    finish(1'b1, REG_SCRATCH, 8'h3C, 0, 1'b1,
           1'b0, REG_SCRATCH, 8'h00);
    launch(1'b0, REG_SCRATCH, 8'h00, 1'b1);
    finish(1'b0, REG_SCRATCH, 8'h00, 0, 1'b0, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      sel = 1'($urandom);
      w = 1'($urandom);
      case ($urandom % 4)
        0: r = REG_VERSION;
        1: r = REG_STATUS;
        2: r = REG_SCRATCH;
        default: r = 7'($urandom);
      endcase
      d = 8'($urandom);
      launch(w, r, d, 1'b0);
      finish(w, r, d, 0, 1'b0, 0, 0, 0);
    end

    chk("mosi_stable", 32'(stab_err), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_master.md
SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 3..255.
REQ-002 clk  input  1  sole clock; all logic on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a register transaction.
REQ-005 write  input  1  1 = register write, 0 = register read; sampled with start.
REQ-006 regnum  input  7  target register number; sampled with start.
REQ-007 wdata  input  8  write data; sampled with start.
REQ-008 busy  output  1  high while a transaction is in progress.
REQ-009 done  output  1  one-cycle pulse when a transaction completes.
REQ-010 rdata  output  8  data byte received during the data phase.
REQ-011 ss  output  1  SPI slave select, active-low.
REQ-012 sclk  output  1  SPI clock, mode 0 (idle low).
REQ-013 mosi  output  1  SPI data to the register-file slave.
REQ-014 miso  input  1  SPI data from the slave; asynchronous to clk.

Function
REQ-015 Each transaction SHALL be 16 bits, MSB first: command byte {write, regnum[6:0]}, then data byte (wdata for writes, 8'h00 for reads).
REQ-016 States SHALL be IDLE, LEAD, SHIFT_HI, SHIFT_LO, TRAIL. Transitions: IDLE->LEAD on start, LEAD->SHIFT_HI after CLK_DIV cycles, SHIFT_HI->SHIFT_LO after CLK_DIV cycles, SHIFT_LO->SHIFT_HI after CLK_DIV cycles (bits 1..15), SHIFT_LO->TRAIL after bit 0, TRAIL->IDLE.
REQ-017 start in IDLE (cycle 0) SHALL latch write/regnum/wdata and, from cycle 1, drive busy=1, ss=0, mosi=bit 15.
REQ-018 sclk SHALL be 1 exactly in SHIFT_HI, 0 otherwise.
REQ-019 mosi SHALL change only on the cycle sclk falls (SHIFT_HI->SHIFT_LO) and SHALL be stable for every cycle sclk is high.
REQ-020 miso SHALL pass through a 2-flop synchronizer; the synchronized value SHALL be sampled on the last cycle of each SHIFT_HI.
REQ-021 Bits sampled during the command byte SHALL be discarded; the 8 data-phase samples SHALL form rdata, MSB first.
REQ-022 In cycle 33*CLK_DIV+1 after cycle 0, ss SHALL return to 1, done SHALL pulse for one cycle, and rdata SHALL update; busy SHALL be 0 from that cycle.
REQ-023 rdata SHALL hold its value until the next done; it updates for writes too (echo of slave output).
REQ-024 start while busy=1 SHALL be ignored without effect on the running transaction.
REQ-025 start in the same cycle done pulses SHALL be accepted; ss SHALL stay high for at least one cycle between transactions.
REQ-026 The SCLK half-period counter SHALL be 8 bits, counting 0..CLK_DIV-1; the bit counter SHALL be 4 bits, counting 15..0, with no wrap beyond bit 0.

Reset
REQ-027 While rst=1: state IDLE, ss=1, sclk=0, mosi=0, busy=0, done=0, rdata=8'h00, synchronizer flops cleared.
REQ-028 rst asserted mid-transaction SHALL abort it: ss=1 and sclk=0 in the cycle after rst is sampled, and no done pulse is issued.

Structure
REQ-029 A shared package SHALL hold the state enum, the command-bit position (RW bit = 7), and the register-number constants used by the slave register map (version 0x00, status/control 0x01, scratchpad 0x0d).
REQ-030 One sub-module is natural: spi_tick, a CLK_DIV half-period tick generator; the synchronizer and FSM SHALL stay inline.

Verification
REQ-031 Write: CLK_DIV=4, start with write=1, regnum=0x0d, wdata=0xA5 -> mosi bit stream 0x8DA5, done at cycle 133, slave scratchpad reads back 0xA5.
REQ-032 Read: start with write=0, regnum=0x00 against slave -> mosi 0x0000, rdata=0x10 at done.
REQ-033 Reset-default read: after rst, read regnum=0x0d -> rdata=0x73.
REQ-034 Busy guard: second start at cycle 50 of a transaction -> ignored, exactly one done, 16 sclk rising edges.
REQ-035 Abort: rst at cycle 60 -> ss=1, sclk=0 next cycle, no done; following read of 0x00 returns 0x10.
REQ-036 Back-to-back: start on the done cycle, CLK_DIV=3 -> ss high exactly one cycle between frames, both transactions correct.
